ysyx_22050019_wb_sched: RTL

Writeback scheduler sitting between the execute/CSR path, the load/store unit and the single register-file write port of the NPC core. Each completing instruction carries a sequence tag. The scheduler grants the write port strictly in program order and registers the selected result onto the port. It raises a one-cycle commit pulse with pc/inst for difftest, and flags protocol errors (tag collisions, stuck requests).

---
 rtl/ysyx_22050019_wb_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ysyx_22050019_wb_sched.sv
// Writeback scheduler: grants the single register-file write port to EXU or LSU strictly
// in sequence-tag order, registers the winner onto wb_*/commit_*, and flags protocol errors.
module ysyx_22050019_wb_sched #(
    parameter int unsigned SEQ_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             exu_valid_i,
    output logic             exu_ready_o,
    input  logic [SEQ_W-1:0] exu_seq_i,
    input  logic             exu_we_i,
    input  logic [4:0]       exu_waddr_i,
    input  logic [63:0]      exu_wdata_i,
    input  logic [63:0]      exu_pc_i,
    input  logic [31:0]      exu_inst_i,

    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic [SEQ_W-1:0] lsu_seq_i,
    input  logic             lsu_we_i,
    input  logic [4:0]       lsu_waddr_i,
    input  logic [63:0]      lsu_wdata_i,
    input  logic [63:0]      lsu_pc_i,
    input  logic [31:0]      lsu_inst_i,

    input  logic             flush_i,
    input  logic [SEQ_W-1:0] flush_seq_i,

    output logic             wb_we_o,
    output logic [4:0]       wb_waddr_o,
    output logic [63:0]      wb_wdata_o,
    output logic             commit_o,
    output logic [63:0]      commit_pc_o,
    output logic [31:0]      commit_inst_o,
    output logic [SEQ_W-1:0] exp_seq_o,
    output logic             err_collide_o,
    output logic             err_timeout_o
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    logic [SEQ_W-1:0] exp_seq_q, exp_seq_d;
    logic [CntW-1:0]  wait_cnt_q, wait_cnt_d;
    logic             wb_we_q, commit_q, err_collide_q, err_timeout_q;
    logic [4:0]       wb_waddr_q;
    logic [63:0]      wb_wdata_q, commit_pc_q;
    logic [31:0]      commit_inst_q;

    logic exu_hit, lsu_hit, exu_grant, lsu_grant, grant, waiting;
    logic        win_we;
    logic [4:0]  win_waddr;
    logic [63:0] win_wdata, win_pc;
    logic [31:0] win_inst;

    always_comb begin
        exu_hit   = exu_valid_i && (exu_seq_i == exp_seq_q);
        lsu_hit   = lsu_valid_i && (lsu_seq_i == exp_seq_q);
        // Ready is gated by reset so nothing is accepted while the core is held.
        lsu_grant = rst_n && lsu_hit && !flush_i;
        exu_grant = rst_n && exu_hit && !lsu_hit && !flush_i;
        grant     = exu_grant || lsu_grant;
        waiting   = (exu_valid_i || lsu_valid_i) && !grant && !flush_i;

        win_we    = lsu_grant ? lsu_we_i    : exu_we_i;
        win_waddr = lsu_grant ? lsu_waddr_i : exu_waddr_i;
        win_wdata = lsu_grant ? lsu_wdata_i : exu_wdata_i;
        win_pc    = lsu_grant ? lsu_pc_i    : exu_pc_i;
        win_inst  = lsu_grant ? lsu_inst_i  : exu_inst_i;

        exp_seq_d = exp_seq_q;
        if (flush_i) begin
            exp_seq_d = flush_seq_i;
        end else if (grant) begin
            exp_seq_d = exp_seq_q + SEQ_W'(1);
        end

        wait_cnt_d = wait_cnt_q;
        if (flush_i || grant) begin
            wait_cnt_d = '0;
        end else if (waiting && wait_cnt_q != CntMax) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_seq_q     <= '0;
            wait_cnt_q    <= '0;
            wb_we_q       <= 1'b0;
            wb_waddr_q    <= '0;
            wb_wdata_q    <= '0;
            commit_q      <= 1'b0;
            commit_pc_q   <= '0;
            commit_inst_q <= '0;
            err_collide_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            exp_seq_q  <= exp_seq_d;
            wait_cnt_q <= wait_cnt_d;
            // x0 is architecturally hardwired, so its writes are suppressed here.
            wb_we_q    <= grant && win_we && (win_waddr != 5'd0);
            commit_q   <= grant;
            if (grant) begin
                wb_waddr_q    <= win_waddr;
                wb_wdata_q    <= win_wdata;
                commit_pc_q   <= win_pc;
                commit_inst_q <= win_inst;
            end
            if (exu_hit && lsu_hit) begin
                err_collide_q <= 1'b1;
            end
            if (waiting && wait_cnt_d == CntMax) begin
                err_timeout_q <= 1'b1;
            end
        end
    end

    assign exu_ready_o   = exu_grant;
    assign lsu_ready_o   = lsu_grant;
    assign wb_we_o       = wb_we_q;
    assign wb_waddr_o    = wb_waddr_q;
    assign wb_wdata_o    = wb_wdata_q;
    assign commit_o      = commit_q;
    assign commit_pc_o   = commit_pc_q;
    assign commit_inst_o = commit_inst_q;
    assign exp_seq_o     = exp_seq_q;
    assign err_collide_o = err_collide_q;
    assign err_timeout_o = err_timeout_q;

endmodule
